// File: rtl/fft_ctrl_pkg.sv
// Shared FFT control definitions: config-word field layout and length legality check.
package fft_ctrl_pkg;

    localparam int unsigned CFG_W        = 24;
    localparam int unsigned CFG_NFFT_LSB = 0;
    localparam int unsigned CFG_NFFT_W   = 5;
    localparam int unsigned CFG_CP_LSB   = 8;
    localparam int unsigned CFG_CP_W     = 7;
    localparam int unsigned CFG_FWD_BIT  = 16;

    // Config word as laid out by the generator; reserved fields are zero.
    typedef struct packed {
        logic [6:0]            rsvd_23_17;
        logic                  fwd_inv;
        logic                  rsvd_15;
        logic [CFG_CP_W-1:0]   cp_len;
        logic [2:0]            rsvd_7_5;
        logic [CFG_NFFT_W-1:0] nfft_log2;
    } fft_cfg_word_t;

    // True when a requested log2 length lies in [lo, hi].
    function automatic logic nfft_log2_legal(input logic [CFG_NFFT_W-1:0] l2,
                                             input int unsigned lo,
                                             input int unsigned hi);
        return (32'(l2) >= lo) && (32'(l2) <= hi);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage valid/ready output register carrying data and tlast.
module axis_out_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready_c,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    // Room for a new beat whenever the held beat is absent or leaving this cycle.
    assign in_ready_c = !(out_valid && !out_ready);

    // Load on accept; drop valid (and tlast with it) once the held beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (in_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_frame_gate.sv
// Frame gate in front of the FFT data input: decodes the config word, marks tlast
// every NFFT samples, and only switches length on a frame boundary.
// Optional macro FFT_FRAME_GATE_FRAME_CNT_EN adds a 32-bit completed-frame counter.
module fft_frame_gate
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MIN_LOG2 = 3,
    parameter int unsigned MAX_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFG_W-1:0]      cfg_tdata,
    input  logic                  cfg_tvalid,
    output logic                  cfg_tready,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CFG_NFFT_W-1:0] nfft_log2,
    output logic                  cfg_err
`ifdef FFT_FRAME_GATE_FRAME_CNT_EN
    ,
    output logic [31:0]           frame_count
`endif
);

    localparam int unsigned CNT_W = MAX_LOG2;

    localparam logic [0:0] WAIT_CFG = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      last_idx_c;
    logic [CFG_NFFT_W-1:0] nfft_d;
    logic                  cfg_err_d;
    logic [CFG_NFFT_W-1:0] cfg_log2_c;
    logic                  cfg_legal_c;
    logic                  boundary_c;
    logic                  is_last_c;
    logic                  out_room_c;
    logic                  load_c;
    logic                  unused_cfg_bits;

    // Only the length field is interpreted; CP length and direction pass by.
    assign cfg_log2_c      = cfg_tdata[CFG_NFFT_LSB +: CFG_NFFT_W];
    assign unused_cfg_bits = ^cfg_tdata[CFG_W-1:CFG_NFFT_W];
    assign cfg_legal_c     = nfft_log2_legal(cfg_log2_c, MIN_LOG2, MAX_LOG2);

    // Frame position bookkeeping; at the longest length the wrap is at all-ones.
    assign last_idx_c = CNT_W'((32'd1 << nfft_log2) - 32'd1);
    assign is_last_c  = (cnt_q == last_idx_c);
    assign boundary_c = (cnt_q == '0) && !m_axis_tvalid;
    assign load_c     = s_axis_tvalid && s_axis_tready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_CFG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake readies and datapath updates.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        nfft_d        = nfft_log2;
        cfg_err_d     = 1'b0;
        cfg_tready    = 1'b0;
        s_axis_tready = 1'b0;
        case (state_q)
            WAIT_CFG: begin
                cfg_tready = !rst;
                if (cfg_tvalid && cfg_tready) begin
                    if (cfg_legal_c) begin
                        nfft_d  = cfg_log2_c;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // A pending config wins over samples at a frame boundary.
                cfg_tready    = boundary_c;
                s_axis_tready = out_room_c && !(cfg_tvalid && boundary_c);
                if (cfg_tvalid && cfg_tready) begin
                    if (cfg_legal_c) begin
                        nfft_d = cfg_log2_c;
                        cnt_d  = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                if (s_axis_tvalid && s_axis_tready) begin
                    cnt_d = is_last_c ? '0 : cnt_q + CNT_W'(1);
                end
            end
            default: state_d = WAIT_CFG;
        endcase
    end

    // Registered counter, active length and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            nfft_log2 <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            nfft_log2 <= nfft_d;
            cfg_err   <= cfg_err_d;
        end
    end

`ifdef FFT_FRAME_GATE_FRAME_CNT_EN
    // Completed frames since the last accepted legal config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
        end else if (cfg_tvalid && cfg_tready && cfg_legal_c) begin
            frame_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_count <= frame_count + 32'd1;
        end
    end
`endif

    axis_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (load_c),
        .in_data    (s_axis_tdata),
        .in_last    (is_last_c),
        .in_ready_c (out_room_c),
        .out_data   (m_axis_tdata),
        .out_valid  (m_axis_tvalid),
        .out_last   (m_axis_tlast),
        .out_ready  (m_axis_tready)
    );

endmodule

// File: tb/tb_fft_frame_gate.sv
// Self-checking bench for fft_frame_gate using an expected-beat scoreboard.
module tb_fft_frame_gate;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] cfg_tdata = '0;
    logic        cfg_tvalid = 1'b0;
    logic        cfg_tready;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [4:0]  nfft_log2;
    logic        cfg_err;
`ifdef FFT_FRAME_GATE_FRAME_CNT_EN
    logic [31:0] frame_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_n = 8;
    int exp_pos = 0;
    int cyc = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    fft_frame_gate dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_tdata     (cfg_tdata),
        .cfg_tvalid    (cfg_tvalid),
        .cfg_tready    (cfg_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .nfft_log2     (nfft_log2),
        .cfg_err       (cfg_err)
`ifdef FFT_FRAME_GATE_FRAME_CNT_EN
        ,
        .frame_count   (frame_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every output handshake for later comparison.
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back({m_axis_tdata, m_axis_tlast});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one config word; returns just after the accepting edge.
    task automatic drive_cfg(input logic [23:0] w, output bit ok);
        ok = 1'b0;
        cfg_tdata = w;
        cfg_tvalid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (cfg_tready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        cfg_tvalid = 1'b0;
    endtask

    // Offer one sample; on acceptance push the expected output beat.
    task automatic drive_sample(input logic [31:0] d, output bit ok);
        beat_t b;
        ok = 1'b0;
        s_axis_tdata = d;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                ok = 1'b1;
                b.data = d;
                b.last = (exp_pos == exp_n - 1);
                exp_q.push_back(b);
                exp_pos = b.last ? 0 : exp_pos + 1;
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset;
        logic [43:0] got;
        rst = 1'b1;
        @(posedge clk);
        #1;
        got = {m_axis_tvalid, m_axis_tlast, m_axis_tdata, nfft_log2, cfg_err, cfg_tready, s_axis_tready};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h, expected all zero", got);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (cfg_tready !== 1'b1 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL wait_cfg_readies: cfg_tready=%b s_axis_tready=%b, expected 1 0", cfg_tready, s_axis_tready);
        end
    endtask

    task automatic test_basic;
        bit ok, all_ok;
        int c0;
        beat_t e, o;
        exp_n = 8; exp_pos = 0;
        drive_cfg(24'h000003, ok);
        checks++;
        if (!ok || nfft_log2 !== 5'd3) begin
            errors++;
            $display("FAIL basic_cfg: accepted=%0b nfft_log2=%0d, expected 1 3", ok, nfft_log2);
        end
        all_ok = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            drive_sample(32'(i), ok);
            all_ok &= ok;
            if (i == 0) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd0) begin
                    errors++;
                    $display("FAIL basic_latency: tvalid=%b data=%h, expected 1 0", m_axis_tvalid, m_axis_tdata);
                end
            end
        end
        checks++;
        if (!all_ok || (cyc - c0) !== 16) begin
            errors++;
            $display("FAIL basic_throughput: ok=%0b cycles=%0d, expected 1 16", all_ok, cyc - c0);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL basic_beat: got data=%h last=%b, expected data=%h last=%b", o.data, o.last, e.data, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_midframe_cfg;
        bit ok, all_ok, early, acc, s_rdy_bad;
        beat_t e, o;
        exp_n = 8; exp_pos = 0;
        all_ok = 1'b1; early = 1'b0; acc = 1'b0; s_rdy_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_sample(32'h100 + 32'(i), ok);
            all_ok &= ok;
        end
        cfg_tdata = 24'h000004;
        cfg_tvalid = 1'b1;
        for (int i = 3; i < 8; i++) begin
            drive_sample(32'h100 + 32'(i), ok);
            all_ok &= ok;
            if (cfg_tready !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early || !all_ok) begin
            errors++;
            $display("FAIL midframe_hold: early_ready=%0b samples_ok=%0b, expected 0 1", early, all_ok);
        end
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            if (cfg_tready) begin
                acc = 1'b1;
                if (s_axis_tready !== 1'b0) s_rdy_bad = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cfg_tvalid = 1'b0;
        checks++;
        if (!acc || s_rdy_bad || nfft_log2 !== 5'd4) begin
            errors++;
            $display("FAIL midframe_accept: accepted=%0b s_ready_in_accept=%0b nfft_log2=%0d, expected 1 0 4", acc, s_rdy_bad, nfft_log2);
        end
        exp_n = 16; exp_pos = 0;
        all_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_sample(32'h200 + 32'(i), ok);
            all_ok &= ok;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (!all_ok || obs_q.size() !== exp_q.size() || exp_q.size() !== 24) begin
            errors++;
            $display("FAIL midframe_count: ok=%0b got %0d beats, expected %0d (24)", all_ok, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midframe_beat: got data=%h last=%b, expected data=%h last=%b", o.data, o.last, e.data, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_cfg_err;
        bit ok;
        logic [23:0] bad [2];
        bad[0] = 24'h000002;
        bad[1] = 24'h000011;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            drive_cfg(bad[k], ok);
            checks++;
            if (!ok || cfg_err !== 1'b1 || s_axis_tready !== 1'b0 || cfg_tready !== 1'b1 || nfft_log2 !== 5'd0) begin
                errors++;
                $display("FAIL err_wait_pulse: ok=%0b cfg_err=%b s_rdy=%b cfg_rdy=%b nfft=%0d, expected 1 1 0 1 0",
                         ok, cfg_err, s_axis_tready, cfg_tready, nfft_log2);
            end
            @(posedge clk);
            #1;
            checks++;
            if (cfg_err !== 1'b0 || s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL err_wait_clear: cfg_err=%b s_rdy=%b, expected 0 0", cfg_err, s_axis_tready);
            end
        end
        drive_cfg(24'h000003, ok);
        drive_cfg(24'h00001F, ok);
        checks++;
        if (!ok || cfg_err !== 1'b1 || nfft_log2 !== 5'd3) begin
            errors++;
            $display("FAIL err_run_keep: ok=%0b cfg_err=%b nfft=%0d, expected 1 1 3", ok, cfg_err, nfft_log2);
        end
        drive_cfg(24'h010F10, ok);
        checks++;
        if (!ok || cfg_err !== 1'b0 || nfft_log2 !== 5'd16) begin
            errors++;
            $display("FAIL cfg_max_len: ok=%0b cfg_err=%b nfft=%0d, expected 1 0 16", ok, cfg_err, nfft_log2);
        end
        drive_cfg(24'h000003, ok);
        checks++;
        if (!ok || nfft_log2 !== 5'd3) begin
            errors++;
            $display("FAIL cfg_back_to_min: ok=%0b nfft=%0d, expected 1 3", ok, nfft_log2);
        end
    endtask

    task automatic test_stall;
        bit ok, all_ok;
        bit pat [4];
        beat_t e, o;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        exp_n = 8; exp_pos = 0;
        all_ok = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    drive_sample(32'h300 + 32'(i), ok);
                    all_ok &= ok;
                end
            end
            begin
                bit prev_stall;
                logic [32:0] prev_beat;
                prev_stall = 1'b0;
                prev_beat = '0;
                for (int c = 0; c < 40; c++) begin
                    m_axis_tready = pat[c % 4];
                    @(negedge clk);
                    if (prev_stall) begin
                        checks++;
                        if (m_axis_tvalid !== 1'b1 || {m_axis_tdata, m_axis_tlast} !== prev_beat) begin
                            errors++;
                            $display("FAIL stall_hold: tvalid=%b beat=%h, expected 1 %h", m_axis_tvalid, {m_axis_tdata, m_axis_tlast}, prev_beat);
                        end
                    end
                    prev_stall = m_axis_tvalid && !m_axis_tready;
                    prev_beat = {m_axis_tdata, m_axis_tlast};
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!all_ok || obs_q.size() !== exp_q.size() || exp_q.size() !== 8) begin
            errors++;
            $display("FAIL stall_count: ok=%0b got %0d beats, expected %0d (8)", all_ok, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_beat: got data=%h last=%b, expected data=%h last=%b", o.data, o.last, e.data, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midframe;
        bit ok, all_ok;
        logic [43:0] got;
        beat_t e, o;
        drive_cfg(24'h000004, ok);
        exp_n = 16; exp_pos = 0;
        all_ok = ok;
        for (int i = 0; i < 5; i++) begin
            drive_sample(32'h400 + 32'(i), ok);
            all_ok &= ok;
        end
        rst = 1'b1;
        #1;
        got = {m_axis_tvalid, m_axis_tlast, m_axis_tdata, nfft_log2, cfg_err, cfg_tready, s_axis_tready};
        checks++;
        if (!all_ok || got !== '0) begin
            errors++;
            $display("FAIL rst_midframe_values: ok=%0b got %h, expected 1 and all zero", all_ok, got);
        end
        exp_q.delete(); obs_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s_axis_tready !== 1'b0 || cfg_tready !== 1'b1) begin
            errors++;
            $display("FAIL rst_needs_cfg: s_rdy=%b cfg_rdy=%b, expected 0 1", s_axis_tready, cfg_tready);
        end
        drive_cfg(24'h000003, ok);
        exp_n = 8; exp_pos = 0;
        all_ok = ok;
        for (int i = 0; i < 8; i++) begin
            drive_sample(32'h500 + 32'(i), ok);
            all_ok &= ok;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!all_ok || obs_q.size() !== exp_q.size() || exp_q.size() !== 8) begin
            errors++;
            $display("FAIL rst_after_count: ok=%0b got %0d beats, expected %0d (8)", all_ok, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rst_after_beat: got data=%h last=%b, expected data=%h last=%b", o.data, o.last, e.data, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef FFT_FRAME_GATE_FRAME_CNT_EN
    task automatic test_frame_count;
        bit ok, all_ok;
        drive_cfg(24'h000003, ok);
        checks++;
        if (!ok || frame_count !== 32'd0) begin
            errors++;
            $display("FAIL fc_clear_first: ok=%0b frame_count=%0d, expected 1 0", ok, frame_count);
        end
        exp_n = 8; exp_pos = 0;
        all_ok = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive_sample(32'h600 + 32'(i), ok);
            all_ok &= ok;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!all_ok || frame_count !== 32'd3) begin
            errors++;
            $display("FAIL fc_three: ok=%0b frame_count=%0d, expected 1 3", all_ok, frame_count);
        end
        drive_cfg(24'h000004, ok);
        checks++;
        if (!ok || frame_count !== 32'd0) begin
            errors++;
            $display("FAIL fc_clear_new_cfg: ok=%0b frame_count=%0d, expected 1 0", ok, frame_count);
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_midframe_cfg();
        test_cfg_err();
        test_stall();
        test_reset_midframe();
`ifdef FFT_FRAME_GATE_FRAME_CNT_EN
        test_frame_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
